// File: rtl/rob_multi_commit.sv
`default_nettype none
// ============================================================================
// Module   : rob_multi_commit
// Purpose  : Circular reorder buffer. One allocation per cycle, completion
//            from writeback, in-order retirement of up to COMMIT_W entries per
//            cycle, rs1/rs2 youngest-producer lookup with forwarding, and a
//            precise flush when a taken branch retires.
// Revision : 1.0  initial release
// ============================================================================
module rob_multi_commit #(
  parameter int DEPTH    = 8,
  parameter int COMMIT_W = 2,
  parameter int XLEN     = 32,
  localparam int RID_W   = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alloc_valid_i,
  input  logic [XLEN-1:0]          alloc_pc_i,
  input  logic [4:0]               alloc_rd_i,
  input  logic                     alloc_we_i,
  output logic                     alloc_ready_o,
  output logic [RID_W-1:0]         alloc_idx_o,
  input  logic                     wb_valid_i,
  input  logic [RID_W-1:0]         wb_idx_i,
  input  logic [XLEN-1:0]          wb_result_i,
  input  logic                     wb_taken_i,
  input  logic [XLEN-1:0]          wb_new_pc_i,
  input  logic [4:0]               rs1_addr_i,
  output logic                     rs1_hit_o,
  output logic [RID_W-1:0]         rs1_idx_o,
  output logic                     rs1_done_o,
  output logic [XLEN-1:0]          rs1_data_o,
  input  logic [4:0]               rs2_addr_i,
  output logic                     rs2_hit_o,
  output logic [RID_W-1:0]         rs2_idx_o,
  output logic                     rs2_done_o,
  output logic [XLEN-1:0]          rs2_data_o,
  output logic [COMMIT_W-1:0]      commit_valid_o,
  output logic [COMMIT_W*XLEN-1:0] commit_pc_o,
  output logic [COMMIT_W*5-1:0]    commit_rd_o,
  output logic [COMMIT_W-1:0]      commit_we_o,
  output logic [COMMIT_W*XLEN-1:0] commit_result_o,
  output logic                     flush_o,
  output logic [XLEN-1:0]          flush_pc_o,
  output logic [RID_W:0]           count_o
);

  localparam logic [RID_W:0] C_FULL = (RID_W+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, taken_q, taken_d, we_q, we_d;
  logic [4:0]       rd_q     [DEPTH];
  logic [4:0]       rd_d     [DEPTH];
  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [XLEN-1:0]  pc_d     [DEPTH];
  logic [XLEN-1:0]  result_q [DEPTH];
  logic [XLEN-1:0]  result_d [DEPTH];
  logic [XLEN-1:0]  new_pc_q [DEPTH];
  logic [XLEN-1:0]  new_pc_d [DEPTH];
  logic [RID_W:0]   head_q, head_d, tail_q, tail_d;

  logic [RID_W-1:0] slot_idx [COMMIT_W];
  logic [RID_W:0]   n_ret;
  logic             alloc_fire;

  logic [4:0]       src_addr [2];
  logic [1:0]       lk_hit, lk_done;
  logic [RID_W-1:0] lk_idx  [2];
  logic [XLEN-1:0]  lk_data [2];

  // Occupancy comes from the wrap-bit pointer difference, so full reads as DEPTH
  assign count_o       = tail_q - head_q;
  assign alloc_ready_o = (count_o != C_FULL) && !flush_o;
  assign alloc_idx_o   = tail_q[RID_W-1:0];
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  genvar k;
  for (k = 0; k < COMMIT_W; k++) begin : g_slot
    assign slot_idx[k] = head_q[RID_W-1:0] + RID_W'(k);
    assign commit_pc_o[k*XLEN +: XLEN]     = commit_valid_o[k] ? pc_q[slot_idx[k]] : '0;
    assign commit_rd_o[k*5 +: 5]           = commit_valid_o[k] ? rd_q[slot_idx[k]] : '0;
    assign commit_result_o[k*XLEN +: XLEN] = commit_valid_o[k] ? result_q[slot_idx[k]] : '0;
    assign commit_we_o[k] = commit_valid_o[k] && we_q[slot_idx[k]] && (rd_q[slot_idx[k]] != 5'd0);
  end

  // Retire the longest done prefix from head, ending after the first taken entry
  always_comb begin
    logic stop;
    stop           = 1'b0;
    commit_valid_o = '0;
    n_ret          = '0;
    flush_o        = 1'b0;
    flush_pc_o     = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (!stop && valid_q[slot_idx[i]] && done_q[slot_idx[i]]) begin
        commit_valid_o[i] = 1'b1;
        n_ret             = n_ret + (RID_W+1)'(1);
        if (taken_q[slot_idx[i]]) begin
          flush_o    = 1'b1;
          flush_pc_o = new_pc_q[slot_idx[i]];
          stop       = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  assign src_addr[0] = rs1_addr_i;
  assign src_addr[1] = rs2_addr_i;

  // Youngest matching producer per source; scanning oldest-to-youngest from head
  // lets the last match win regardless of where the raw indices wrap
  always_comb begin
    logic [RID_W-1:0] idx, sel;
    logic             hit, byp;
    for (int s = 0; s < 2; s++) begin
      hit = 1'b0;
      sel = '0;
      for (int a = 0; a < DEPTH; a++) begin
        idx = head_q[RID_W-1:0] + RID_W'(a);
        if (valid_q[idx] && we_q[idx] && (rd_q[idx] == src_addr[s]) && (src_addr[s] != 5'd0)) begin
          hit = 1'b1;
          sel = idx;
        end
      end
      byp        = wb_valid_i && (wb_idx_i == sel);
      lk_hit[s]  = hit;
      lk_idx[s]  = hit ? sel : '0;
      lk_done[s] = hit && (done_q[sel] || byp);
      lk_data[s] = !hit ? '0 : (byp ? wb_result_i : result_q[sel]);
    end
  end

  assign rs1_hit_o  = lk_hit[0];
  assign rs1_idx_o  = lk_idx[0];
  assign rs1_done_o = lk_done[0];
  assign rs1_data_o = lk_data[0];
  assign rs2_hit_o  = lk_hit[1];
  assign rs2_idx_o  = lk_idx[1];
  assign rs2_done_o = lk_done[1];
  assign rs2_data_o = lk_data[1];

  // Next state: writeback, then retirement, then allocation; a flush empties the buffer
  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    taken_d  = taken_q;
    we_d     = we_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    result_d = result_q;
    new_pc_d = new_pc_q;
    if (wb_valid_i && valid_q[wb_idx_i]) begin
      done_d[wb_idx_i]   = 1'b1;
      result_d[wb_idx_i] = wb_result_i;
      taken_d[wb_idx_i]  = wb_taken_i;
      new_pc_d[wb_idx_i] = wb_new_pc_i;
    end
    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_valid_o[i]) valid_d[slot_idx[i]] = 1'b0;
    end
    if (alloc_fire) begin
      valid_d[tail_q[RID_W-1:0]] = 1'b1;
      done_d[tail_q[RID_W-1:0]]  = 1'b0;
      taken_d[tail_q[RID_W-1:0]] = 1'b0;
      we_d[tail_q[RID_W-1:0]]    = alloc_we_i;
      rd_d[tail_q[RID_W-1:0]]    = alloc_rd_i;
      pc_d[tail_q[RID_W-1:0]]    = alloc_pc_i;
    end
    head_d = head_q + n_ret;
    tail_d = tail_q + {{RID_W{1'b0}}, alloc_fire};
    if (flush_o) begin
      valid_d = '0;
      tail_d  = head_d;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      done_q   <= '0;
      taken_q  <= '0;
      we_q     <= '0;
      rd_q     <= '{default: '0};
      pc_q     <= '{default: '0};
      result_q <= '{default: '0};
      new_pc_q <= '{default: '0};
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      taken_q  <= taken_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      new_pc_q <= new_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

endmodule
`default_nettype wire
